rs_station_age: RTL and testbench

- Parametrised reservation station that sits between decode/issue and one ALU.
- Holds up to RS_DEPTH instructions and captures operands from N_CDB result buses, including same-cycle bypass on insert.
- Each cycle it selects the oldest ready entry, not the lowest-index one.
- Output to the ALU uses a valid/ready handshake with backpressure.
- A flush input squashes all contents on a branch mispredict.

---
 rtl/rs_station_age_pkg.sv | 23 ++
 rtl/rs_station_age_age_matrix.sv | 51 +++++
 rtl/rs_station_age.sv | 215 +++++++++++++++++++++
 tb/tb_rs_station_age.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_station_age_pkg.sv
// Shared defaults and opcode class constants for the ALU reservation station.
package rs_station_age_pkg;

    localparam int RS_DEPTH_DEF = 8;
    localparam int XLEN_DEF     = 32;
    localparam int TAG_W_DEF    = 5;
    localparam int OPC_W_DEF    = 6;
    localparam int N_CDB_DEF    = 2;

    typedef enum logic [OPC_W_DEF-1:0] {
        OPC_ADD = 6'd0,
        OPC_SUB = 6'd1,
        OPC_AND = 6'd2,
        OPC_OR  = 6'd3,
        OPC_XOR = 6'd4,
        OPC_SLL = 6'd5,
        OPC_SRL = 6'd6,
        OPC_SLT = 6'd7,
        OPC_BEQ = 6'd8,
        OPC_LUI = 6'd9
    } opc_class_e;

endpackage

// File: rtl/rs_station_age_age_matrix.sv
// Age matrix for the reservation station: tracks insertion order and grants the oldest requester.
module rs_age_matrix
    import rs_station_age_pkg::*;
#(
    parameter int RS_DEPTH = RS_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        ins_en,
    input  logic [$clog2(RS_DEPTH)-1:0] ins_idx,
    input  logic [RS_DEPTH-1:0]         busy,
    input  logic [RS_DEPTH-1:0]         req,
    output logic [RS_DEPTH-1:0]         gnt
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    // older_q[i][j] = 1: entry i was inserted before entry j
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
    logic [RS_DEPTH-1:0]               blocked;

    // Released slots keep stale bits; busy/req mask them until the slot is reused.
    always_comb begin
        older_d = older_q;
        if (clr) begin
            older_d = '0;
        end else if (ins_en) begin
            older_d[ins_idx] = '0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (busy[j] && (IDX_W'(j) != ins_idx)) older_d[j][ins_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        blocked = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (req[j] && older_q[j][i]) blocked[i] = 1'b1;
            end
        end
        gnt = req & ~blocked;
    end

    always_ff @(posedge clk) begin
        if (rst) older_q <= '0;
        else     older_q <= older_d;
    end

endmodule

// File: rtl/rs_station_age.sv
// Reservation station for one ALU: CDB capture with insert bypass, oldest-ready select, valid/ready dispatch.
module rs_station_age
    import rs_station_age_pkg::*;
#(
    parameter int RS_DEPTH = RS_DEPTH_DEF,
    parameter int XLEN     = XLEN_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int OPC_W    = OPC_W_DEF,
    parameter int N_CDB    = N_CDB_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OPC_W-1:0]            in_opc,
    input  logic [XLEN-1:0]             in_pc,
    input  logic [XLEN-1:0]             in_imm,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic                        in_rdy1,
    input  logic                        in_rdy2,
    input  logic [XLEN-1:0]             in_vq1,
    input  logic [XLEN-1:0]             in_vq2,
    input  logic [N_CDB-1:0]            cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]      cdb_tag,
    input  logic [N_CDB*XLEN-1:0]       cdb_val,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OPC_W-1:0]            out_opc,
    output logic [XLEN-1:0]             out_pc,
    output logic [XLEN-1:0]             out_imm,
    output logic [TAG_W-1:0]            out_tag,
    output logic [XLEN-1:0]             out_v1,
    output logic [XLEN-1:0]             out_v2,
    output logic [$clog2(RS_DEPTH):0]   occupancy,
    output logic                        nex_ava
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_DEPTH-1:0] busy_q, busy_d, op1_rdy_q, op1_rdy_d, op2_rdy_q, op2_rdy_d;
    logic [OPC_W-1:0]    opc_q [RS_DEPTH], opc_d [RS_DEPTH];
    logic [XLEN-1:0]     pc_q  [RS_DEPTH], pc_d  [RS_DEPTH];
    logic [XLEN-1:0]     imm_q [RS_DEPTH], imm_d [RS_DEPTH];
    logic [TAG_W-1:0]    tag_q [RS_DEPTH], tag_d [RS_DEPTH];
    logic [XLEN-1:0]     v1_q  [RS_DEPTH], v1_d  [RS_DEPTH];
    logic [XLEN-1:0]     v2_q  [RS_DEPTH], v2_d  [RS_DEPTH];

    logic                out_valid_q, out_valid_d;
    logic [OPC_W-1:0]    out_opc_q, out_opc_d;
    logic [XLEN-1:0]     out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [TAG_W-1:0]    out_tag_q, out_tag_d;
    logic [XLEN-1:0]     out_v1_q, out_v1_d, out_v2_q, out_v2_d;
    logic [CNT_W-1:0]    occ_q, occ_d, free_cnt;

    logic [RS_DEPTH-1:0] req, gnt;
    logic [IDX_W-1:0]    free_idx;
    logic                insert_fire, dispatch_fire;
    logic [XLEN:0]       byp1, byp2;
    logic [XLEN:0]       wake1 [RS_DEPTH], wake2 [RS_DEPTH];

    // Returns {hit, value}; lowest-numbered matching bus wins.
    function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] tag);
        logic [XLEN:0] res;
        res = '0;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == tag)) res = {1'b1, cdb_val[k*XLEN +: XLEN]};
        end
        return res;
    endfunction

    // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
        byp1 = cdb_lookup(in_vq1[TAG_W-1:0]);
        byp2 = cdb_lookup(in_vq2[TAG_W-1:0]);
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake1[i] = cdb_lookup(v1_q[i][TAG_W-1:0]);
            wake2[i] = cdb_lookup(v2_q[i][TAG_W-1:0]);
        end
    end

    assign req           = busy_q & op1_rdy_q & op2_rdy_q;
    assign in_ready      = ~&busy_q;
    assign insert_fire   = in_valid & in_ready & rdy & ~flush;
    assign dispatch_fire = (|gnt) & (~out_valid_q | out_ready) & rdy & ~flush;

    rs_age_matrix #(.RS_DEPTH(RS_DEPTH)) u_age (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .ins_en  (insert_fire),
        .ins_idx (free_idx),
        .busy    (busy_q),
        .req     (req),
        .gnt     (gnt)
    );

    always_comb begin
        busy_d    = busy_q;
        op1_rdy_d = op1_rdy_q;
        op2_rdy_d = op2_rdy_q;
        opc_d     = opc_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        tag_d     = tag_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        if (rdy) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy_q[i] && !op1_rdy_q[i] && wake1[i][XLEN]) begin
                    op1_rdy_d[i] = 1'b1;
                    v1_d[i]      = wake1[i][XLEN-1:0];
                end
                if (busy_q[i] && !op2_rdy_q[i] && wake2[i][XLEN]) begin
                    op2_rdy_d[i] = 1'b1;
                    v2_d[i]      = wake2[i][XLEN-1:0];
                end
                if (dispatch_fire && gnt[i]) busy_d[i] = 1'b0;
            end
        end
        if (insert_fire) begin
            busy_d[free_idx]    = 1'b1;
            opc_d[free_idx]     = in_opc;
            pc_d[free_idx]      = in_pc;
            imm_d[free_idx]     = in_imm;
            tag_d[free_idx]     = in_tag;
            op1_rdy_d[free_idx] = in_rdy1 | byp1[XLEN];
            op2_rdy_d[free_idx] = in_rdy2 | byp2[XLEN];
            v1_d[free_idx]      = (!in_rdy1 && byp1[XLEN]) ? byp1[XLEN-1:0] : in_vq1;
            v2_d[free_idx]      = (!in_rdy2 && byp2[XLEN]) ? byp2[XLEN-1:0] : in_vq2;
        end
        if (flush) busy_d = '0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_opc_d   = out_opc_q;
        out_pc_d    = out_pc_q;
        out_imm_d   = out_imm_q;
        out_tag_d   = out_tag_q;
        out_v1_d    = out_v1_q;
        out_v2_d    = out_v2_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (dispatch_fire) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (gnt[i]) begin
                    out_opc_d = opc_q[i];
                    out_pc_d  = pc_q[i];
                    out_imm_d = imm_q[i];
                    out_tag_d = tag_q[i];
                    out_v1_d  = v1_q[i];
                    out_v2_d  = v2_q[i];
                end
            end
        end else if (rdy && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        occ_d    = flush ? '0 : occ_q + CNT_W'(insert_fire) - CNT_W'(dispatch_fire);
        free_cnt = CNT_W'(RS_DEPTH) - occ_q;
    end

    assign nex_ava = (free_cnt >= CNT_W'(2)) || ((free_cnt == CNT_W'(1)) && !insert_fire) || dispatch_fire;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            occ_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    // NOTE: payload storage is not reset; busy_q and out_valid_q qualify every use of it.
    always_ff @(posedge clk) begin
        op1_rdy_q <= op1_rdy_d;
        op2_rdy_q <= op2_rdy_d;
        opc_q     <= opc_d;
        pc_q      <= pc_d;
        imm_q     <= imm_d;
        tag_q     <= tag_d;
        v1_q      <= v1_d;
        v2_q      <= v2_d;
        out_opc_q <= out_opc_d;
        out_pc_q  <= out_pc_d;
        out_imm_q <= out_imm_d;
        out_tag_q <= out_tag_d;
        out_v1_q  <= out_v1_d;
        out_v2_q  <= out_v2_d;
    end

    assign out_valid = out_valid_q;
    assign out_opc   = out_opc_q;
    assign out_pc    = out_pc_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;
    assign out_v1    = out_v1_q;
    assign out_v2    = out_v2_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_rs_station_age.sv
// Directed bench for rs_station_age: latency, oldest-first select, bypass, full, backpressure, flush.
module tb_rs_station_age;
    import rs_station_age_pkg::*;

    localparam int D  = 8;
    localparam int XL = 32;
    localparam int TW = 5;
    localparam int OW = 6;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst, rdy, flush, in_valid, in_ready;
    logic [OW-1:0]   in_opc;
    logic [XL-1:0]   in_pc, in_imm, in_vq1, in_vq2;
    logic [TW-1:0]   in_tag;
    logic            in_rdy1, in_rdy2;
    logic [NC-1:0]   cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*XL-1:0] cdb_val;
    logic            out_valid, out_ready;
    logic [OW-1:0]   out_opc;
    logic [XL-1:0]   out_pc, out_imm, out_v1, out_v2;
    logic [TW-1:0]   out_tag;
    logic [3:0]      occupancy;
    logic            nex_ava;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rs_station_age dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc), .in_pc(in_pc),
        .in_imm(in_imm), .in_tag(in_tag), .in_rdy1(in_rdy1), .in_rdy2(in_rdy2),
        .in_vq1(in_vq1), .in_vq2(in_vq2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_opc(out_opc), .out_pc(out_pc),
        .out_imm(out_imm), .out_tag(out_tag), .out_v1(out_v1), .out_v2(out_v2),
        .occupancy(occupancy), .nex_ava(nex_ava)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ins(input logic [OW-1:0] opc, input logic [TW-1:0] tag,
                             input logic r1, input logic [XL-1:0] q1,
                             input logic r2, input logic [XL-1:0] q2);
        in_valid = 1'b1;
        in_opc   = opc;
        in_tag   = tag;
        in_pc    = 32'h1000 + {27'd0, tag};
        in_imm   = {27'd0, tag} + 32'd100;
        in_rdy1  = r1;
        in_vq1   = q1;
        in_rdy2  = r2;
        in_vq2   = q2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic set_cdb(input int k, input logic [TW-1:0] tag, input logic [XL-1:0] val);
        cdb_valid[k]         = 1'b1;
        cdb_tag[k*TW +: TW]  = tag;
        cdb_val[k*XL +: XL]  = val;
    endtask

    task automatic clear_cdb();
        cdb_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_opc = '0; in_pc = '0; in_imm = '0; in_tag = '0;
        in_rdy1 = 1'b0; in_rdy2 = 1'b0; in_vq1 = '0; in_vq2 = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_nex_ava", nex_ava, 1);

        // Basic insert, both operands ready: dispatched one edge later.
        drive_ins(OPC_OR, 5'd2, 1'b1, 32'd5, 1'b1, 32'd7);
        tick(); idle();
        check("t1_occ_after_ins", occupancy, 1);
        check("t1_no_early_valid", out_valid, 0);
        tick();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_v1", out_v1, 5);
        check("t1_out_v2", out_v2, 7);
        check("t1_out_tag", out_tag, 2);
        check("t1_out_opc", out_opc, 3);
        check("t1_out_pc", out_pc, 32'h1002);
        check("t1_out_imm", out_imm, 32'd102);
        check("t1_occ_after_disp", occupancy, 0);
        tick();
        check("t1_valid_drops", out_valid, 0);

        // Oldest-first: A lands in slot 1, B reuses slot 0, A must still win.
        drive_ins(OPC_ADD, 5'd3, 1'b1, 32'h11, 1'b1, 32'h22);
        tick();
        drive_ins(OPC_ADD, 5'd4, 1'b0, 32'd9, 1'b1, 32'd1);
        tick();
        check("t2_x_out_tag", out_tag, 3);
        drive_ins(OPC_SUB, 5'd5, 1'b0, 32'd9, 1'b1, 32'd2);
        tick(); idle();
        check("t2_idle_valid", out_valid, 0);
        check("t2_occ", occupancy, 2);
        set_cdb(0, 5'd9, 32'h55);
        tick(); clear_cdb();
        check("t2_no_comb_wake", out_valid, 0);
        tick();
        check("t2_a_tag", out_tag, 4);
        check("t2_a_v1", out_v1, 32'h55);
        check("t2_a_v2", out_v2, 1);
        tick();
        check("t2_b_tag", out_tag, 5);
        check("t2_b_v1", out_v1, 32'h55);
        check("t2_b_v2", out_v2, 2);
        tick();
        check("t2_end_valid", out_valid, 0);
        check("t2_end_occ", occupancy, 0);

        // Same-cycle CDB bypass on insert (bus 1).
        drive_ins(OPC_XOR, 5'd7, 1'b1, 32'h12, 1'b0, 32'd6);
        set_cdb(1, 5'd6, 32'hAB);
        tick(); idle(); clear_cdb();
        check("t3_occ", occupancy, 1);
        tick();
        check("t3_valid", out_valid, 1);
        check("t3_v2_bypass", out_v2, 32'hAB);
        check("t3_v1", out_v1, 32'h12);
        check("t3_tag", out_tag, 7);
        tick();

        // Two buses match the same tag on wakeup: bus 0 wins.
        drive_ins(OPC_AND, 5'd8, 1'b0, 32'd12, 1'b1, 32'd0);
        tick(); idle();
        set_cdb(0, 5'd12, 32'h33);
        set_cdb(1, 5'd12, 32'h44);
        tick(); clear_cdb();
        tick();
        check("t3b_tag", out_tag, 8);
        check("t3b_v1_prio", out_v1, 32'h33);
        tick();
        check("t3b_end_valid", out_valid, 0);

        // Fill all entries with unready operands.
        for (int i = 0; i < D; i++) begin
            if (i == D - 1) begin
                idle(); #1;
                check("t4_one_free_no_ins", nex_ava, 1);
            end
            drive_ins(OPC_ADD, TW'(10 + i), 1'b0, 32'd31, 1'b1, XL'(i));
            #1;
            if (i == D - 1) check("t4_one_free_ins", nex_ava, 0);
            tick();
        end
        check("t4_full_in_ready", in_ready, 0);
        check("t4_full_occ", occupancy, 8);
        check("t4_full_nex_ava", nex_ava, 0);
        tick();
        check("t4_extra_ignored", occupancy, 8);
        idle();
        set_cdb(0, 5'd31, 32'h77);
        tick(); clear_cdb();
        check("t4_woken_no_valid", out_valid, 0);
        check("t4_full_still", in_ready, 0);
        check("t4_nex_ava_dispatch", nex_ava, 1);
        for (int i = 0; i < D; i++) begin
            tick();
            check("t4_drain_tag", out_tag, 64'(10 + i));
            check("t4_drain_v1", out_v1, 32'h77);
            check("t4_drain_v2", out_v2, 64'(i));
            if (i == 0) check("t4_in_ready_after", in_ready, 1);
        end
        tick();
        check("t4_end_valid", out_valid, 0);
        check("t4_end_occ", occupancy, 0);

        // Backpressure with three ready entries, plus a rdy=0 stall.
        out_ready = 1'b0;
        drive_ins(OPC_ADD, 5'd20, 1'b1, 32'h20, 1'b1, 32'h0);
        tick();
        check("t5_occ1", occupancy, 1);
        drive_ins(OPC_ADD, 5'd21, 1'b1, 32'h21, 1'b1, 32'h0);
        tick();
        check("t5_first_out", out_tag, 20);
        drive_ins(OPC_ADD, 5'd22, 1'b1, 32'h22, 1'b1, 32'h0);
        tick(); idle();
        check("t5_occ2", occupancy, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_tag", out_tag, 20);
            check("t5_hold_occ", occupancy, 2);
        end
        rdy = 1'b0; out_ready = 1'b1;
        drive_ins(OPC_ADD, 5'd23, 1'b1, 32'h23, 1'b1, 32'h0);
        tick();
        check("t5_rdy0_tag", out_tag, 20);
        check("t5_rdy0_valid", out_valid, 1);
        check("t5_rdy0_occ", occupancy, 2);
        rdy = 1'b1; idle();
        tick();
        check("t5_second", out_tag, 21);
        tick();
        check("t5_third", out_tag, 22);
        tick();
        check("t5_end_valid", out_valid, 0);

        // Flush with five busy entries and a held output; CDB in the flush cycle is ignored.
        out_ready = 1'b0;
        drive_ins(OPC_ADD, 5'd1, 1'b1, 32'd1, 1'b1, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive_ins(OPC_ADD, TW'(24 + i), 1'b0, 32'd31, 1'b1, 32'd0);
            tick();
        end
        check("t6_pre_occ", occupancy, 5);
        check("t6_pre_valid", out_valid, 1);
        flush = 1'b1;
        set_cdb(0, 5'd31, 32'h99);
        drive_ins(OPC_ADD, 5'd30, 1'b1, 32'd3, 1'b1, 32'd3);
        tick();
        flush = 1'b0; idle(); clear_cdb();
        check("t6_flush_valid", out_valid, 0);
        check("t6_flush_occ", occupancy, 0);
        check("t6_flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        check("t6_no_stale_dispatch", out_valid, 0);
        check("t6_occ_stays", occupancy, 0);
        drive_ins(OPC_ADD, 5'd9, 1'b1, 32'hA, 1'b1, 32'hB);
        tick(); idle();
        tick();
        check("t6_post_valid", out_valid, 1);
        check("t6_post_tag", out_tag, 9);
        check("t6_post_v2", out_v2, 32'hB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
